sbox_lut_loader: RTL and testbench
==================================

Name: sbox_lut_loader

Overview:
- Register-interface initiator that programs the 32-entry, 5-bit ASCON S-box lookup table held in the S-box register block.
- Issues 8 word writes, one per 4-entry row, on a reg_req_t/reg_rsp_t bus; optionally reads every row back and compares it.
- Sits between the boot/config controller and the S-box register block, so the permutation datapath can run without host software programming the table.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of S-box row 0 register; row r is at BASE_ADDR + 4*r.
- TIMEOUT, 16, maximum cycles one bus transfer waits for ready before it aborts with an error.

Ports:
- clk_i  input  1  clock
- rst_n_i  input  1  asynchronous active-low reset
- start_i  input  1  single-cycle start pulse; ignored while busy_o=1
- use_ext_i  input  1  sampled at start: 1 = program table_i, 0 = program the default ASCON table
- verify_i  input  1  sampled at start: 1 = perform the read-back pass
- table_i  input  [31:0][4:0]  external table, entry i = S(i); sampled at start
- reg_req_o  output  reg_req_t  bus request (addr, write, wdata, wstrb, valid)
- reg_rsp_i  input  reg_rsp_t  bus response (rdata, error, ready)
- busy_o  output  1  high from the cycle after start until done
- done_o  output  1  one-cycle pulse at the end of the operation, whether it passes or fails
- err_o  output  1  sticky failure flag; cleared by the next accepted start
- err_row_o  output  3  row that caused the first failure; valid while err_o=1

Behaviour:
- Reset values: all outputs 0, reg_req_o all fields 0, FSM in IDLE, row counter 0.
- Word packing: row r word = {3'b0,S(4r+3), 3'b0,S(4r+2), 3'b0,S(4r+1), 3'b0,S(4r)}.
  - entry k occupies bits [8k+4:8k]; pad bits are written as 0.
  - wstrb = 4'hF on writes and 4'h0 on reads.
- Start (IDLE and start_i=1):
  - table, use_ext_i and verify_i are latched; row counter set to 0; err_o and err_row_o cleared.
  - Next state is WRITE.
- Handshake:
  - valid is held with stable addr, write and wdata until the cycle in which valid && ready.
  - The next request is presented no earlier than the cycle after acceptance, so valid deasserts for one cycle between transfers.
  - rdata and error are sampled in the acceptance cycle.
- FSM states and transitions:
  - IDLE -> WRITE on start.
  - WRITE: one write per row. On acceptance, row increments. After row 7: READ if verify is latched, else DONE.
  - READ: rows 0..7 are read again. On acceptance, rdata is compared against the packed word with pad bits masked. After row 7 with no mismatch: DONE.
  - DONE: done_o=1 for one cycle, busy_o falls in the same cycle, then IDLE.
- Failures: rsp.error=1, a read mismatch, or a wait count reaching TIMEOUT.
  - err_o is set and err_row_o takes the current row.
  - The operation aborts and the FSM goes to DONE.
  - An aborted transfer drops valid in the next cycle.
- Timeout: a counter clears whenever a new request starts and counts every cycle valid is high without ready. At count TIMEOUT-1 with no ready, the block aborts.
- Row counter is 3 bits; the 7->0 wrap is the pass-change condition. No wrap-around write is ever issued.
- Total latency with ready tied high: 1 + 2*8 write cycles (+ 2*8 read cycles) + 1 done cycle.
- Asynchronous reset mid-transfer drops valid immediately. No partial-row state is retained.

Decomposition:
- ascon_sbox_lut_pkg holds:
  - ASCON_SBOX: the 32x5 default table, {04,0B,1F,14,1A,15,09,02,1B,05,08,12,1D,03,06,1C,1E,13,07,0E,00,0D,11,18,10,0C,01,19,16,0A,0F,17}.
  - The loader_state_e enum.
  - SBOX_ROWS=8 and ENTRY_PAD_MASK=32'h1F1F1F1F.
  - The function pack_row(table, row).
- One sub-module, reg_bus_xfer: a single-transfer engine with the valid/ready hold, response capture and timeout counter. The FSM drives it with req/ack.

Test Plan:
- Default table, no verify, ready always 1 -> 8 writes with rows 0..7 at addresses BASE+0..BASE+1C. Row 0 wdata=32'h141F0B04, row 7 wdata=32'h170F0A16. done_o pulses on cycle 18 after start; err_o=0.
- Default table, verify, slave model returns the written data with pad bits set to 1 -> the read pass passes with err_o=0, which checks the pad masking. done_o pulses on cycle 34.
- External identity table (S(i)=i), verify, slave corrupts row 5 rdata to 32'h00000000 -> err_o=1, err_row_o=5. No read of row 6 is issued.
- ready held low on the row 3 write for TIMEOUT cycles -> abort with err_o=1, err_row_o=3. valid drops and done_o pulses.
- rsp.error=1 on the row 0 write -> immediate abort with err_row_o=0. A subsequent start clears err_o and the run completes cleanly.
- start_i pulsed while busy, then rst_n_i asserted during the row 4 write -> the start is ignored; on reset all outputs read 0 at once and the next start begins again at row 0.

Source files
------------

// File: rtl/ascon_sbox_lut_pkg.sv
// Shared types, constants and the row packing helper for the ASCON S-box table loader.
package ascon_sbox_lut_pkg;

  localparam int          SBOX_ROWS      = 8;
  localparam int          SBOX_ENTRIES   = 32;
  localparam logic [31:0] ENTRY_PAD_MASK = 32'h1F1F1F1F;

  typedef logic [SBOX_ENTRIES-1:0][4:0] sbox_table_t;

  // Listed from entry 31 down to entry 0, so ASCON_SBOX[i] = S(i).
  localparam sbox_table_t ASCON_SBOX = {
    5'h17, 5'h0F, 5'h0A, 5'h16, 5'h19, 5'h01, 5'h0C, 5'h10,
    5'h18, 5'h11, 5'h0D, 5'h00, 5'h0E, 5'h07, 5'h13, 5'h1E,
    5'h1C, 5'h06, 5'h03, 5'h1D, 5'h12, 5'h08, 5'h05, 5'h1B,
    5'h02, 5'h09, 5'h15, 5'h1A, 5'h14, 5'h1F, 5'h0B, 5'h04
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE
  } loader_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  // Entry k of the row lands in bits [8k+4:8k]; the three pad bits above it are zero.
  function automatic logic [31:0] pack_row(input sbox_table_t tbl, input logic [2:0] row);
    logic [31:0] word;
    word = '0;
    for (int k = 0; k < 4; k++) begin
      word[8*k +: 8] = {3'b000, tbl[{row, 2'(k)}]};
    end
    return word;
  endfunction

endpackage

// File: rtl/sbox_lut_loader_if.sv
// Register bus between the loader (master) and the S-box register block (slave).
interface sbox_lut_loader_if;
  import ascon_sbox_lut_pkg::*;

  reg_req_t req;
  reg_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/sbox_lut_loader_reg_bus_xfer.sv
// Single-transfer engine: holds a request until accepted or timed out, then pulses ack for one cycle.
module reg_bus_xfer
  import ascon_sbox_lut_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      req_i,
  input  logic [31:0]               addr_i,
  input  logic                      write_i,
  input  logic [31:0]               wdata_i,
  sbox_lut_loader_if.master         bus,
  output logic                      busy_o,
  output logic                      ack_o,
  output logic                      err_o,
  output logic [31:0]               rdata_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  reg_req_t    req_q, req_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    req_d   = req_q;
    tmo_d   = tmo_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (req_q.valid) begin
      if (bus.rsp.ready) begin
        req_d.valid = 1'b0;
        ack_d       = 1'b1;
        err_d       = bus.rsp.error;
        rdata_d     = bus.rsp.rdata;
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        req_d.valid = 1'b0;
        ack_d       = 1'b1;
        err_d       = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else if (req_i) begin
      req_d.addr  = addr_i;
      req_d.write = write_i;
      req_d.wdata = write_i ? wdata_i : '0;
      req_d.wstrb = write_i ? 4'hF : 4'h0;
      req_d.valid = 1'b1;
      tmo_d       = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      req_q   <= '0;
      tmo_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req = req_q;
  assign busy_o  = req_q.valid;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/sbox_lut_loader.sv
// Programs the 32-entry ASCON S-box table row by row over the register bus, with optional read-back check.
module sbox_lut_loader
  import ascon_sbox_lut_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             use_ext_i,
  input  logic             verify_i,
  input  logic [31:0][4:0] table_i,
  output reg_req_t         reg_req_o,
  input  reg_rsp_t         reg_rsp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [2:0]       err_row_o
);

  loader_state_e state_q, state_d;
  logic [2:0]    row_q, row_d;
  sbox_table_t   tbl_q, tbl_d;
  logic          verify_q, verify_d;
  logic          err_q, err_d;
  logic [2:0]    err_row_q, err_row_d;

  logic          xfer_req, xfer_write, xfer_busy, xfer_ack, xfer_err;
  logic [31:0]   xfer_addr, xfer_wdata, xfer_rdata;
  logic          fail;

  sbox_lut_loader_if bus_if ();

  reg_bus_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req_i   (xfer_req),
    .addr_i  (xfer_addr),
    .write_i (xfer_write),
    .wdata_i (xfer_wdata),
    .bus     (bus_if),
    .busy_o  (xfer_busy),
    .ack_o   (xfer_ack),
    .err_o   (xfer_err),
    .rdata_o (xfer_rdata)
  );

  assign reg_req_o  = bus_if.req;
  assign bus_if.rsp = reg_rsp_i;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    tbl_d     = tbl_q;
    verify_d  = verify_q;
    err_d     = err_q;
    err_row_d = err_row_q;
    fail      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          tbl_d     = use_ext_i ? table_i : ASCON_SBOX;
          verify_d  = verify_i;
          row_d     = '0;
          err_d     = 1'b0;
          err_row_d = '0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE, ST_READ: begin
        if (xfer_ack) begin
          fail = xfer_err ||
                 (state_q == ST_READ &&
                  (xfer_rdata & ENTRY_PAD_MASK) != pack_row(tbl_q, row_q));
          if (fail) begin
            err_d     = 1'b1;
            err_row_d = row_q;
            state_d   = ST_DONE;
          end else begin
            row_d = row_q + 3'd1;
            if (row_q == 3'(SBOX_ROWS - 1)) begin
              state_d = (state_q == ST_WRITE && verify_q) ? ST_READ : ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // The next request is launched in the cycle after acceptance, addressed by the updated row.
    xfer_req   = !xfer_busy &&
                 (state_q == ST_WRITE || state_q == ST_READ) &&
                 (state_d == ST_WRITE || state_d == ST_READ);
    xfer_write = (state_d == ST_WRITE);
    xfer_addr  = BASE_ADDR + {27'd0, row_d, 2'b00};
    xfer_wdata = pack_row(tbl_q, row_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      // NOTE: the latched table is small and is reset with everything else, so no stale entries survive.
      tbl_q     <= '0;
      verify_q  <= 1'b0;
      err_q     <= 1'b0;
      err_row_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      tbl_q     <= tbl_d;
      verify_q  <= verify_d;
      err_q     <= err_d;
      err_row_q <= err_row_d;
    end
  end

  assign busy_o    = (state_q == ST_WRITE || state_q == ST_READ);
  assign done_o    = (state_q == ST_DONE);
  assign err_o     = err_q;
  assign err_row_o = err_row_q;

endmodule

// File: tb/tb_sbox_lut_loader.sv
// Self-checking bench: slave model on the register bus plus a table-level reference of the expected traffic.
module tb_sbox_lut_loader;
  import ascon_sbox_lut_pkg::*;

  localparam logic [31:0] BASE    = 32'h4000_0100;
  localparam int          TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             start_i = 1'b0;
  logic             use_ext_i = 1'b0;
  logic             verify_i = 1'b0;
  logic [31:0][4:0] table_i = '0;
  logic             busy_o, done_o, err_o;
  logic [2:0]       err_row_o;

  sbox_lut_loader_if bus_if ();

  sbox_lut_loader #(.BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .use_ext_i (use_ext_i),
    .verify_i  (verify_i),
    .table_i   (table_i),
    .reg_req_o (bus_if.req),
    .reg_rsp_i (bus_if.rsp),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .err_row_o (err_row_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference table, natural order: S(0) first.
  logic [4:0] ascon_ref [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };
  logic [4:0] cur_tbl [32];

  function automatic logic [31:0] ref_word(input int r);
    logic [31:0] w;
    w = 0;
    for (int k = 0; k < 4; k++) w = w + (32'(cur_tbl[4*r+k]) << (8*k));
    return w;
  endfunction

  // Slave model configuration
  int          stall_row = -1;
  int          err_row_cfg = -1;
  int          corrupt_row = -1;
  bit          rand_ready = 0;
  bit          pad_ones = 1;
  bit          rdy_rand = 1;
  int          low_run = 0;
  logic [31:0] mem [8];
  logic [2:0]  s_row;

  always_comb begin
    s_row = 3'((bus_if.req.addr - BASE) >> 2);
    bus_if.rsp = '0;
    bus_if.rsp.ready = rand_ready ? rdy_rand : 1'b1;
    if (bus_if.req.write && int'(s_row) == stall_row) bus_if.rsp.ready = 1'b0;
    if (bus_if.req.write && int'(s_row) == err_row_cfg) bus_if.rsp.error = 1'b1;
    bus_if.rsp.rdata = mem[s_row] | (pad_ones ? 32'hE0E0E0E0 : 32'h0);
    if (!bus_if.req.write && int'(s_row) == corrupt_row) bus_if.rsp.rdata = '0;
  end

  always @(posedge clk) begin
    #2;
    rdy_rand = (low_run >= 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
    low_run  = rdy_rand ? 0 : low_run + 1;
  end

  // Bus monitor: transaction log and handshake rule tracking
  reg_req_t xact_q [$];
  reg_req_t prev_req;
  bit       prev_valid = 0, prev_acc = 0;
  int       proto_err = 0;
  int       stall_cnt = 0;

  always @(negedge clk) begin
    if (rst_n_i) begin
      automatic bit acc = bus_if.req.valid && bus_if.rsp.ready;
      if (bus_if.req.valid && prev_acc) proto_err++;
      if (bus_if.req.valid && prev_valid && !prev_acc &&
          (bus_if.req.addr != prev_req.addr || bus_if.req.write != prev_req.write ||
           bus_if.req.wdata != prev_req.wdata)) proto_err++;
      if (bus_if.req.valid && !bus_if.rsp.ready) stall_cnt++;
      if (acc) begin
        xact_q.push_back(bus_if.req);
        if (bus_if.req.write) mem[3'((bus_if.req.addr - BASE) >> 2)] = bus_if.req.wdata;
      end
      prev_valid = bus_if.req.valid;
      prev_acc   = acc;
      prev_req   = bus_if.req;
    end
  end

  // Expected outcome derived from the slave configuration
  int e_err, e_row, e_nwr, e_nrd;

  task automatic predict(input bit ver);
    logic [31:0] back;
    e_err = 0; e_row = 0; e_nwr = 8; e_nrd = 0;
    if (err_row_cfg >= 0) begin
      e_nwr = err_row_cfg + 1; e_err = 1; e_row = err_row_cfg;
    end else if (stall_row >= 0) begin
      e_nwr = stall_row; e_err = 1; e_row = stall_row;
    end else if (ver) begin
      for (int r = 0; r < 8; r++) begin
        back  = (r == corrupt_row) ? 32'h0 : (ref_word(r) | (pad_ones ? 32'hE0E0E0E0 : 32'h0));
        e_nrd = r + 1;
        if ((back & 32'h1F1F1F1F) != ref_word(r)) begin
          e_err = 1; e_row = r;
          break;
        end
      end
    end
  endtask

  task automatic kick(input bit ext, input bit ver);
    xact_q.delete();
    proto_err = 0;
    stall_cnt = 0;
    @(negedge clk);
    use_ext_i = ext;
    verify_i  = ver;
    for (int i = 0; i < 32; i++) table_i[i] = ext ? cur_tbl[i] : 5'($urandom);
    start_i = 1'b1;
    @(negedge clk);
    start_i   = 1'b0;
    use_ext_i = ~ext;
    verify_i  = ~ver;
    for (int i = 0; i < 32; i++) table_i[i] = 5'($urandom);
    check("busy_c1", 32'(busy_o), 32'd1);
    check("err_clr_c1", 32'(err_o), 32'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int c = 2; c <= 600; c++) begin
      @(negedge clk);
      if (done_o) begin
        cyc = c;
        break;
      end
    end
    if (cyc < 0) begin
      check("done_seen", 32'd0, 32'd1);
    end else begin
      check("busy_at_done", 32'(busy_o), 32'd0);
      check("valid_at_done", 32'(bus_if.req.valid), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done_o), 32'd0);
    end
  endtask

  task automatic check_op(input string tag, input bit ver);
    bit w;
    int r;
    predict(ver);
    check({tag, "_err"}, 32'(err_o), 32'(e_err));
    if (e_err != 0) check({tag, "_err_row"}, 32'(err_row_o), 32'(e_row));
    check({tag, "_proto"}, 32'(proto_err), 32'd0);
    check({tag, "_nxact"}, 32'(xact_q.size()), 32'(e_nwr + e_nrd));
    for (int i = 0; i < xact_q.size() && i < e_nwr + e_nrd; i++) begin
      w = (i < e_nwr);
      r = w ? i : i - e_nwr;
      check($sformatf("%s_addr[%0d]", tag, i), xact_q[i].addr, BASE + 32'(4*r));
      check($sformatf("%s_write[%0d]", tag, i), 32'(xact_q[i].write), 32'(w));
      check($sformatf("%s_wstrb[%0d]", tag, i), 32'(xact_q[i].wstrb), w ? 32'hF : 32'h0);
      if (w) check($sformatf("%s_wdata[%0d]", tag, i), xact_q[i].wdata, ref_word(r));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, found;
    bit  ext, ver;

    cur_tbl = ascon_ref;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_err_row", 32'(err_row_o), 32'd0);
    check("rst_valid", 32'(bus_if.req.valid), 32'd0);
    check("rst_addr", bus_if.req.addr, 32'd0);
    check("rst_wdata", bus_if.req.wdata, 32'd0);
    rst_n_i = 1'b1;

    // Default table, write only, ready tied high
    kick(1'b0, 1'b0);
    wait_done(cyc);
    check("t1_done_cycle", 32'(cyc), 32'd18);
    check_op("t1", 1'b0);
    if (xact_q.size() == 8) begin
      check("t1_row0_word", xact_q[0].wdata, 32'h141F0B04);
      check("t1_row7_word", xact_q[7].wdata, 32'h170F0A16);
    end

    // Default table with read-back; slave sets pad bits on read data
    kick(1'b0, 1'b1);
    wait_done(cyc);
    check("t2_done_cycle", 32'(cyc), 32'd34);
    check_op("t2", 1'b1);

    // Identity table, row 5 read corrupted
    for (int i = 0; i < 32; i++) cur_tbl[i] = 5'(i);
    corrupt_row = 5;
    kick(1'b1, 1'b1);
    wait_done(cyc);
    check_op("t3", 1'b1);
    check("t3_err_row", 32'(err_row_o), 32'd5);
    corrupt_row = -1;

    // Row 3 write never gets ready
    cur_tbl = ascon_ref;
    stall_row = 3;
    kick(1'b0, 1'b0);
    wait_done(cyc);
    check_op("t4", 1'b0);
    check("t4_wait_cycles", 32'(stall_cnt), 32'(TIMEOUT));
    stall_row = -1;

    // Error response on row 0, then a clean rerun
    err_row_cfg = 0;
    kick(1'b0, 1'b0);
    wait_done(cyc);
    check_op("t5a", 1'b0);
    err_row_cfg = -1;
    kick(1'b0, 1'b0);
    wait_done(cyc);
    check("t5b_done_cycle", 32'(cyc), 32'd18);
    check_op("t5b", 1'b0);

    // Start while busy is ignored; reset during the row 4 write
    kick(1'b0, 1'b0);
    found = -1;
    for (int c = 2; c <= 100; c++) begin
      @(negedge clk);
      if (c == 5) start_i = 1'b1;
      if (c == 6) start_i = 1'b0;
      if (bus_if.req.valid && bus_if.req.write && bus_if.req.addr == BASE + 32'd16) begin
        found = c;
        break;
      end
    end
    start_i = 1'b0;
    check("t6_row4_cycle", 32'(found), 32'd10);
    rst_n_i = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus_if.req.valid), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    check("t6_rst_done", 32'(done_o), 32'd0);
    check("t6_rst_err", 32'(err_o), 32'd0);
    check("t6_rst_addr", bus_if.req.addr, 32'd0);
    check("t6_rst_wdata", bus_if.req.wdata, 32'd0);
    check("t6_rst_wstrb", 32'(bus_if.req.wstrb), 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    kick(1'b0, 1'b0);
    wait_done(cyc);
    check("t6_done_cycle", 32'(cyc), 32'd18);
    check_op("t6", 1'b0);

    // Randomized tables, options, ready back-pressure and read corruption
    rand_ready = 1;
    for (int n = 0; n < 8; n++) begin
      ext         = 1'($urandom_range(0, 1));
      ver         = 1'($urandom_range(0, 1));
      pad_ones    = 1'($urandom_range(0, 1));
      corrupt_row = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : -1;
      for (int i = 0; i < 32; i++) cur_tbl[i] = ext ? 5'($urandom) : ascon_ref[i];
      kick(ext, ver);
      wait_done(cyc);
      check_op($sformatf("rnd%0d", n), ver);
    end
    rand_ready  = 0;
    corrupt_row = -1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
